// File: rtl/jtag_scan_sequencer.sv
// Host-side JTAG scan sequencer: expands RESET / SHIFT_IR / SHIFT_DR / RUN_IDLE commands into
// registered TMS/TDI streams for a TAP controller and gathers TDO into a response word.
module jtag_scan_sequencer #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LEN_W  = 6
) (
   input  logic              tck_i,
   input  logic              trst_ni,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [1:0]        cmd_type_i,
   input  logic [LEN_W-1:0]  cmd_len_i,
   input  logic [DATA_W-1:0] cmd_data_i,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_data_o,
   output logic              tms_o,
   output logic              tdi_o,
   input  logic              tdo_i,
   output logic              busy_o
);

   // Counter must reach 5 for the reset walk and DATA_W-1 for shifts.
   localparam int unsigned CntW = (LEN_W > 3) ? LEN_W : 3;
   localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [1:0] {
      CmdReset   = 2'b00,
      CmdShiftIr = 2'b01,
      CmdShiftDr = 2'b10,
      CmdRunIdle = 2'b11
   } cmdT;

   typedef enum logic [2:0] {
      StInit,
      StReady,
      StPre,
      StShift,
      StPost,
      StIdleWait
   } stateT;

   stateT             stateQ, stateD;
   cmdT               typeQ, typeD;
   logic [CntW-1:0]   cntQ, cntD;
   logic [CntW-1:0]   lenQ, lenD;
   logic [CntW-1:0]   effLen;
   logic [DATA_W-1:0] dataQ, dataD;
   logic [DATA_W-1:0] capQ, capD;
   logic [DATA_W-1:0] rspDataQ, rspDataD;
   logic              rspValidQ, rspValidD;
   logic              tmsQ, tmsD;
   logic              tdiQ, tdiD;
   logic              finish;

   // TMS bit idx of the walk that precedes the shift (or the whole walk for RESET).
   function automatic logic preBit(input cmdT t, input logic [CntW-1:0] idx);
      case (t)
         CmdShiftDr: return idx == CntW'(0);
         CmdShiftIr: return idx < CntW'(2);
         default:    return idx < CntW'(5);
      endcase
   endfunction

   function automatic logic [CntW-1:0] preLast(input cmdT t);
      case (t)
         CmdShiftDr: return CntW'(2);
         CmdShiftIr: return CntW'(3);
         default:    return CntW'(5);
      endcase
   endfunction

   always_comb begin
      effLen = CntW'(cmd_len_i);
      if (cmd_len_i == '0) begin
         effLen = CntW'(1);
      end else if (cmd_type_i != CmdRunIdle && 32'(cmd_len_i) > DATA_W) begin
         effLen = CntW'(DATA_W);
      end
   end

   always_comb begin
      stateD    = stateQ;
      typeD     = typeQ;
      cntD      = cntQ;
      lenD      = lenQ;
      dataD     = dataQ;
      capD      = capQ;
      rspDataD  = rspDataQ;
      rspValidD = 1'b0;
      tmsD      = tmsQ;
      tdiD      = tdiQ;
      finish    = 1'b0;

      unique case (stateQ)
         StInit: begin
            if (cntQ == CntW'(5)) begin
               stateD = StReady;
               cntD   = '0;
               tmsD   = 1'b0;
            end else begin
               cntD = cntQ + CntW'(1);
               tmsD = preBit(CmdReset, cntQ + CntW'(1));
            end
         end
         StReady: begin
            tmsD = 1'b0;
            tdiD = 1'b0;
            if (cmd_valid_i) begin
               typeD = cmdT'(cmd_type_i);
               lenD  = effLen;
               dataD = cmd_data_i;
               capD  = '0;
               cntD  = '0;
               if (cmdT'(cmd_type_i) == CmdRunIdle) begin
                  stateD = StIdleWait;
                  tmsD   = 1'b0;
               end else begin
                  stateD = StPre;
                  tmsD   = preBit(cmdT'(cmd_type_i), '0);
               end
            end
         end
         StPre: begin
            if (cntQ == preLast(typeQ)) begin
               if (typeQ == CmdReset) begin
                  finish   = 1'b1;
                  rspDataD = '0;
               end else begin
                  stateD = StShift;
                  cntD   = '0;
                  tmsD   = (lenQ == CntW'(1));
                  tdiD   = dataQ[0];
                  dataD  = dataQ >> 1;
               end
            end else begin
               cntD = cntQ + CntW'(1);
               tmsD = preBit(typeQ, cntQ + CntW'(1));
            end
         end
         StShift: begin
            capD[cntQ[IdxW-1:0]] = tdo_i;
            if (cntQ == lenQ - CntW'(1)) begin
               stateD = StPost;
               cntD   = '0;
               tmsD   = 1'b1;
               tdiD   = 1'b0;
            end else begin
               cntD  = cntQ + CntW'(1);
               tmsD  = (cntQ + CntW'(2) == lenQ);
               tdiD  = dataQ[0];
               dataD = dataQ >> 1;
            end
         end
         StPost: begin
            if (cntQ == '0) begin
               cntD = CntW'(1);
               tmsD = 1'b0;
            end else begin
               finish   = 1'b1;
               rspDataD = capQ;
            end
         end
         StIdleWait: begin
            if (cntQ == lenQ - CntW'(1)) begin
               finish   = 1'b1;
               rspDataD = '0;
            end else begin
               cntD = cntQ + CntW'(1);
            end
         end
         default: begin
            stateD = StInit;
            cntD   = '0;
            tmsD   = 1'b1;
            tdiD   = 1'b0;
         end
      endcase

      if (finish) begin
         stateD    = StReady;
         cntD      = '0;
         tmsD      = 1'b0;
         tdiD      = 1'b0;
         rspValidD = 1'b1;
      end
   end

   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         stateQ    <= StInit;
         typeQ     <= CmdReset;
         cntQ      <= '0;
         lenQ      <= CntW'(1);
         dataQ     <= '0;
         capQ      <= '0;
         rspDataQ  <= '0;
         rspValidQ <= 1'b0;
         tmsQ      <= 1'b1;
         tdiQ      <= 1'b0;
      end else begin
         stateQ    <= stateD;
         typeQ     <= typeD;
         cntQ      <= cntD;
         lenQ      <= lenD;
         dataQ     <= dataD;
         capQ      <= capD;
         rspDataQ  <= rspDataD;
         rspValidQ <= rspValidD;
         tmsQ      <= tmsD;
         tdiQ      <= tdiD;
      end
   end

   assign cmd_ready_o = (stateQ == StReady);
   assign busy_o      = ~cmd_ready_o;
   assign rsp_valid_o = rspValidQ;
   assign rsp_data_o  = rspDataQ;
   assign tms_o       = tmsQ;
   assign tdi_o       = tdiQ;

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Scoreboard bench for jtag_scan_sequencer with a behavioural TAP state model on tms_o.
module tb_jtag_scan_sequencer;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned LEN_W  = 6;
   localparam logic [1:0] TReset = 2'b00;
   localparam logic [1:0] TIr    = 2'b01;
   localparam logic [1:0] TDr    = 2'b10;
   localparam logic [1:0] TIdle  = 2'b11;

   typedef enum logic [3:0] {
      Tlr, Rti, SelDr, CapDr, ShDr, Ex1Dr, PaDr, Ex2Dr, UpDr,
      SelIr, CapIr, ShIr, Ex1Ir, PaIr, Ex2Ir, UpIr
   } tapT;

   typedef struct {
      logic [DATA_W-1:0] data;
      int                lat;
      int                acc;
   } expT;

   logic              tck = 1'b0;
   logic              trstN;
   logic              cmdValid, cmdReady, rspValid, tms, tdi, tdo, busy, loopMode;
   logic [1:0]        cmdType;
   logic [LEN_W-1:0]  cmdLen;
   logic [DATA_W-1:0] cmdData, rspData;

   expT        expQ[$];
   expT        monE;
   tapT        tap = ShDr;
   logic       tmsPre;
   logic [63:0] tmsHist = '0;
   int shDrCnt = 0, shIrCnt = 0, upDrCnt = 0, upIrCnt = 0;
   int cyc = 0, checks = 0, errors = 0, lastRsp = 0, lastAcc = 0;

   jtag_scan_sequencer #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .tck_i      (tck),
      .trst_ni    (trstN),
      .cmd_valid_i(cmdValid),
      .cmd_ready_o(cmdReady),
      .cmd_type_i (cmdType),
      .cmd_len_i  (cmdLen),
      .cmd_data_i (cmdData),
      .rsp_valid_o(rspValid),
      .rsp_data_o (rspData),
      .tms_o      (tms),
      .tdi_o      (tdi),
      .tdo_i      (tdo),
      .busy_o     (busy)
   );

   always #5 tck = ~tck;
   assign tdo = loopMode ? tdi : ~tdi;

   function automatic tapT tapNext(input tapT s, input logic m);
      case (s)
         Tlr:     return m ? Tlr   : Rti;
         Rti:     return m ? SelDr : Rti;
         SelDr:   return m ? SelIr : CapDr;
         CapDr:   return m ? Ex1Dr : ShDr;
         ShDr:    return m ? Ex1Dr : ShDr;
         Ex1Dr:   return m ? UpDr  : PaDr;
         PaDr:    return m ? Ex2Dr : PaDr;
         Ex2Dr:   return m ? UpDr  : ShDr;
         UpDr:    return m ? SelDr : Rti;
         SelIr:   return m ? Tlr   : CapIr;
         CapIr:   return m ? Ex1Ir : ShIr;
         ShIr:    return m ? Ex1Ir : ShIr;
         Ex1Ir:   return m ? UpIr  : PaIr;
         PaIr:    return m ? Ex2Ir : PaIr;
         Ex2Ir:   return m ? UpIr  : ShIr;
         default: return m ? SelDr : Rti;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(posedge tck) cyc <= cyc + 1;

   // TAP model sees the TMS value that was stable before each rising edge.
   always @(negedge tck) tmsPre <= tms;

   always @(posedge tck) begin
      if (trstN) begin
         tap     <= tapNext(tap, tmsPre);
         tmsHist <= {tmsHist[62:0], tmsPre};
         if (tap == ShDr) shDrCnt <= shDrCnt + 1;
         if (tap == ShIr) shIrCnt <= shIrCnt + 1;
         if (tapNext(tap, tmsPre) == UpDr) upDrCnt <= upDrCnt + 1;
         if (tapNext(tap, tmsPre) == UpIr) upIrCnt <= upIrCnt + 1;
      end
   end

   always @(negedge tck) begin
      if (trstN && tap != ShDr && tap != ShIr) chk("tdi quiet outside shift", 64'(tdi), 64'(0));
   end

   always @(negedge tck) begin
      if (rspValid) begin
         lastRsp = cyc;
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected rsp: got data 0x%0h expected no response", rspData);
         end else begin
            monE = expQ.pop_front();
            chk("rsp data", 64'(rspData), 64'(monE.data));
            chk("rsp latency", 64'(cyc - monE.acc), 64'(monE.lat));
         end
      end
   end

   task automatic checkReset();
      chk("reset tms", 64'(tms), 64'(1));
      chk("reset tdi", 64'(tdi), 64'(0));
      chk("reset ready", 64'(cmdReady), 64'(0));
      chk("reset busy", 64'(busy), 64'(1));
      chk("reset rsp_valid", 64'(rspValid), 64'(0));
      chk("reset rsp_data", 64'(rspData), 64'(0));
   endtask

   // Called at a negedge with reset asserted; releases it and follows the INIT walk.
   task automatic powerUp();
      trstN = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge tck);
         chk("init tms", 64'(tms), 64'(k <= 4));
         chk("init ready", 64'(cmdReady), 64'(k == 6));
      end
      chk("init tap idle", 64'(tap), 64'(Rti));
   endtask

   task automatic issue(input logic [1:0] t, input int len, input logic [DATA_W-1:0] d,
                        input logic [DATA_W-1:0] expData, input int expLat);
      int  n;
      expT e;
      @(negedge tck);
      cmdType  = t;
      cmdLen   = LEN_W'(len);
      cmdData  = d;
      cmdValid = 1'b1;
      n = 0;
      while (!cmdReady && n < 200) begin
         @(negedge tck);
         n++;
      end
      if (!cmdReady) begin
         checks++;
         errors++;
         $display("FAIL accept timeout: got ready=0 after %0d cycles expected ready=1", n);
      end else begin
         e.data = expData;
         e.lat  = expLat;
         e.acc  = cyc + 1;
         lastAcc = cyc + 1;
         expQ.push_back(e);
         @(negedge tck);
      end
      // Later changes on the command bus must be ignored.
      cmdValid = 1'b0;
      cmdType  = ~t;
      cmdLen   = ~cmdLen;
      cmdData  = ~d;
   endtask

   task automatic waitRsp();
      int n;
      n = 0;
      while (!rspValid && n < 300) begin
         @(negedge tck);
         n++;
      end
      if (!rspValid) begin
         checks++;
         errors++;
         $display("FAIL rsp timeout: got no rsp_valid expected a response");
      end
      #1;
   endtask

   task automatic runCmd(input logic [1:0] t, input int len, input logic [DATA_W-1:0] d,
                         input logic [DATA_W-1:0] expData, input int expLat, input int expSh,
                         input string name);
      int sd0, si0, ud0, ui0;
      sd0 = shDrCnt;
      si0 = shIrCnt;
      ud0 = upDrCnt;
      ui0 = upIrCnt;
      issue(t, len, d, expData, expLat);
      waitRsp();
      chk({name, " tap idle"}, 64'(tap), 64'(Rti));
      chk({name, " dr shifts"}, 64'(shDrCnt - sd0), 64'((t == TDr) ? expSh : 0));
      chk({name, " ir shifts"}, 64'(shIrCnt - si0), 64'((t == TIr) ? expSh : 0));
      chk({name, " dr updates"}, 64'(upDrCnt - ud0), 64'((t == TDr) ? 1 : 0));
      chk({name, " ir updates"}, 64'(upIrCnt - ui0), 64'((t == TIr) ? 1 : 0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int sd0;
      trstN    = 1'b0;
      cmdValid = 1'b0;
      cmdType  = '0;
      cmdLen   = '0;
      cmdData  = '0;
      loopMode = 1'b1;
      repeat (3) @(negedge tck);
      checkReset();
      powerUp();

      runCmd(TDr, 8, 32'hA5, 32'hA5, 13, 8, "dr8");
      chk("dr8 tms stream", 64'(tmsHist[12:0]), 64'(13'b1000000000110));

      loopMode = 1'b0;
      runCmd(TIr, 4, 32'h3, 32'hC, 10, 4, "ir4");
      chk("ir4 tms stream", 64'(tmsHist[9:0]), 64'(10'b1100000110));
      loopMode = 1'b1;

      runCmd(TDr, 40, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 37, 32, "dr40 clamp");
      runCmd(TDr, 0, 32'h3, 32'h1, 6, 1, "dr0");
      runCmd(TIdle, 0, 32'hFFFF_FFFF, 32'h0, 1, 0, "idle0");
      runCmd(TIdle, 63, 32'h1234_5678, 32'h0, 63, 0, "idle63");
      runCmd(TReset, 9, 32'hFFFF_FFFF, 32'h0, 6, 0, "reset");
      chk("reset tms stream", 64'(tmsHist[5:0]), 64'(6'b111110));

      issue(TIdle, 3, 32'h0, 32'h0, 3);
      issue(TDr, 8, 32'h3C, 32'h3C, 13);
      chk("b2b accept gap", 64'(lastAcc - lastRsp), 64'(1));
      waitRsp();
      chk("b2b tap idle", 64'(tap), 64'(Rti));

      sd0 = shDrCnt;
      issue(TDr, 8, 32'hFF, 32'hFF, 13);
      repeat (7) @(negedge tck);
      chk("abort tap shifting", 64'(tap), 64'(ShDr));
      chk("abort bits shifted", 64'(shDrCnt - sd0), 64'(4));
      trstN = 1'b0;
      expQ.delete();
      #1;
      checkReset();
      repeat (3) @(negedge tck);
      powerUp();

      loopMode = 1'b0;
      runCmd(TDr, 8, 32'h5A, 32'hA5, 13, 8, "recover dr8");
      loopMode = 1'b1;

      repeat (2) @(negedge tck);
      chk("scoreboard drained", 64'(expQ.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
